// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw asynchronous level, with optional one-cycle edge pulses.
// Optional feature macro: INPUT_CONDITIONER_EDGE_EN enables the registered rise/fall pulses.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  output logic y,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   go_high;
  logic                   go_low;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], a_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Commit decision: the DEBOUNCE_CYCLES-th consecutive sample at the new level.
  always_comb begin
    go_high = 1'b0;
    go_low  = 1'b0;
    case (state)
      ST_LOW:   go_high = s && SINGLE;
      CHK_HIGH: go_high = s && (cnt == CNT_LAST);
      ST_HIGH:  go_low  = !s && SINGLE;
      CHK_LOW:  go_low  = !s && (cnt == CNT_LAST);
      default: begin
        go_high = 1'b0;
        go_low  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
      y     <= 1'b0;
    end else if (go_high) begin
      state <= ST_HIGH;
      cnt   <= '0;
      y     <= 1'b1;
    end else if (go_low) begin
      state <= ST_LOW;
      cnt   <= '0;
      y     <= 1'b0;
    end else begin
      case (state)
        ST_LOW: begin
          if (s) begin
            state <= CHK_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        CHK_HIGH: begin
          if (s) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          end else begin
            state <= ST_LOW;
            cnt   <= '0;
          end
        end
        ST_HIGH: begin
          if (!s) begin
            state <= CHK_LOW;
            cnt   <= CNT_ONE;
          end
        end
        CHK_LOW: begin
          if (!s) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
          end else begin
            state <= ST_HIGH;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef INPUT_CONDITIONER_EDGE_EN
  // Pulses come from the same commit decision as y, so they align with its change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= go_high;
      fall <= go_low;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed-vector bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic a_in;
  logic y;
  logic rise;
  logic fall;

  int checks;
  int failures;

  typedef struct {
    logic rst;
    logic a_in;
    logic exp_y;
    logic exp_rise;
    logic exp_fall;
    string tag;
  } vec_t;

  vec_t vecs[$];

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_in (a_in),
    .y    (y),
    .rise (rise),
    .fall (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic a, input logic ey,
                        input logic er, input logic ef, input string tag);
    vec_t v;
    v.rst = r; v.a_in = a; v.exp_y = ey; v.exp_rise = er; v.exp_fall = ef; v.tag = tag;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic r, input logic a);
    @(negedge clk);
    rst  = r;
    a_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic ey, input logic er, input logic ef);
    logic er_g;
    logic ef_g;
    er_g = er & EDGE_EN;
    ef_g = ef & EDGE_EN;
    checks += 3;
    if (y !== ey) begin
      failures++;
      $display("[TB] FAIL %s y: got %b expected %b at %0t", tag, y, ey, $time);
    end
    if (rise !== er_g) begin
      failures++;
      $display("[TB] FAIL %s rise: got %b expected %b at %0t", tag, rise, er_g, $time);
    end
    if (fall !== ef_g) begin
      failures++;
      $display("[TB] FAIL %s fall: got %b expected %b at %0t", tag, fall, ef_g, $time);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    a_in     = 1'b0;

    for (int i = 0; i < 3; i++)  addVec(1, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 20; i++) addVec(0, 0, 0, 0, 0, "idle_low");
    // Rising: s valid after edge 2, commit on edge 6.
    for (int i = 0; i < 5; i++)  addVec(0, 1, 0, 0, 0, "rise_wait");
    addVec(0, 1, 1, 1, 0, "rise_commit");
    addVec(0, 1, 1, 0, 0, "rise_after");
    for (int i = 0; i < 3; i++)  addVec(0, 1, 1, 0, 0, "high_hold");
    // Four low samples then a one-cycle blip: commit low on edge 6, blip rejected.
    for (int i = 0; i < 4; i++)  addVec(0, 0, 1, 0, 0, "fall_wait");
    addVec(0, 1, 1, 0, 0, "fall_blip_in");
    addVec(0, 0, 0, 0, 1, "fall_commit");
    for (int i = 0; i < 6; i++)  addVec(0, 0, 0, 0, 0, "fall_after");
    // Three-cycle high pulse is one sample short of a commit.
    for (int i = 0; i < 3; i++)  addVec(0, 1, 0, 0, 0, "short_high");
    for (int i = 0; i < 8; i++)  addVec(0, 0, 0, 0, 0, "short_after");
    for (int i = 0; i < 12; i++) addVec(0, logic'(i % 2), 0, 0, 0, "toggle");
    for (int i = 0; i < 4; i++)  addVec(0, 0, 0, 0, 0, "settle");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].a_in);
      checkOutput(vecs[i].tag, vecs[i].exp_y, vecs[i].exp_rise, vecs[i].exp_fall);
    end

    // Reset during CHK_HIGH with cnt=2 aborts the check; full latency after release.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1);
      checkOutput("abort_pre", 0, 0, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_async", 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("abort_held", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1);
      checkOutput("abort_relatch", 0, 0, 0);
    end
    applyStimulus(0, 1);
    checkOutput("abort_commit", 1, 1, 0);
    applyStimulus(0, 1);
    checkOutput("abort_after", 1, 0, 0);

    // Asynchronous reset clears y=1 without a clock edge; first edge after release is quiet.
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_clear", 0, 0, 0);
    @(posedge clk);
    #1;
    checkOutput("async_held", 0, 0, 0);
    applyStimulus(0, 1);
    checkOutput("first_edge", 0, 0, 0);
    applyStimulus(0, 0);
    checkOutput("second_edge", 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0);
      checkOutput("post_quiet", 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
